// File: rtl/multibyte_add_pkg.sv
// multibyte_add_pkg: shared types for the byte-serial add/subtract sequencer.
// Holds the controller state encoding and the byte-index width helper.
package multibyte_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A one-byte datapath still needs a 1-bit index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder88.sv
// adder88: 8-bit ripple-carry adder, the single shared byte slice.
// z = x + y + cin, with cout taken from bit 7.
module adder88 (
    output logic       cout,
    output logic [7:0] z,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       cin
);

    logic [8:0] c;

    always_comb begin
        c    = '0;
        z    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            z[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = c[8];

endmodule

// File: rtl/multibyte_add_seq.sv
// multibyte_add_seq: NBYTES-wide add/subtract, one byte per clock, LSB first.
// A single adder88 is time-multiplexed; the inter-byte carry is registered.
module multibyte_add_seq
    import multibyte_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = idx_w(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;

    logic [7:0]    add_z;
    logic          add_co;

    adder88 u_adder (
        .cout (add_co),
        .z    (add_z),
        .x    (a_q[8*idx_q +: 8]),
        .y    (b_q[8*idx_q +: 8]),
        .cin  (carry_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1, so the carry seeds the +1.
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[8*idx_q +: 8] = add_z;
                carry_d             = add_co;
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (add_z[7] != a_q[W-1]);
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb_multibyte_add_seq: directed and random checks of the byte-serial adder
// against an arithmetic reference model (NBYTES = 4).
module tb_multibyte_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    multibyte_add_seq #(.NBYTES(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic s,
                                          input logic c);
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint unsigned r;
        longint sr;
        logic co;
        logic ov;
        if (s) begin
            r  = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy + 64'(c);
            co = (r >= 64'h1_0000_0000);
            sr = sx + sy + longint'(c);
        end
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ov, co, r[31:0]};
    endfunction

    // Drives one operation and returns what the DUT shows in its done cycle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input logic tc,
                          output logic [31:0] rs, output logic rc,
                          output logic ro, output logic rbusy,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout; ro = ovf; rbusy = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== 36'h0) begin
            errors++;
            $display("FAIL reset_in: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== 36'h0) begin
            errors++;
            $display("FAIL reset_out: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [8] = '{32'h000000FF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'd5, 32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h0};
        logic [31:0] vb [8] = '{32'h1, 32'h1, 32'h1, 32'd7, 32'd5,
                                32'h1, 32'h1, 32'h80000000};
        logic vs [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
        logic vc [8] = '{0, 0, 1, 1, 0, 0, 0, 0};
        logic [31:0] es [8] = '{32'h00000100, 32'h0, 32'h1, 32'hFFFFFFFE,
                                32'h2, 32'h80000000, 32'h7FFFFFFF, 32'h80000000};
        logic ec [8] = '{0, 1, 1, 0, 1, 0, 1, 0};
        logic eo [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic [31:0] rs;
        logic rc, ro, rb;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(va[i], vb[i], vs[i], vc[i], rs, rc, ro, rb, lat);
            checks++;
            if (lat != 4 || rb !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_timing: got lat=%0d busy=%b want lat=4 busy=0",
                         i, lat, rb);
            end
            checks++;
            if ({ro, rc, rs} !== {eo[i], ec[i], es[i]}) begin
                errors++;
                $display("FAIL dir%0d_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                         i, rs, rc, ro, es[i], ec[i], eo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ta, tb_v, rs;
        logic ts, tc, rc, ro, rb;
        logic [33:0] e;
        int lat;
        for (int i = 0; i < 40; i++) begin
            ta = $urandom; tb_v = $urandom; ts = $urandom; tc = $urandom;
            if (i % 8 == 0) tb_v = ta;
            e = model(ta, tb_v, ts, tc);
            run_op(ta, tb_v, ts, tc, rs, rc, ro, rb, lat);
            checks++;
            if (lat != 4 || {ro, rc, rs} !== e) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h sub=%b cin=%b got lat=%0d %b/%b/%h want lat=4 %b/%b/%h",
                         i, ta, tb_v, ts, tc, lat, ro, rc, rs, e[33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [33:0] e;
        int lat;
        int extra;
        e = model(32'h0000ABCD, 32'h00001111, 1'b0, 1'b0);
        @(negedge clk);
        a = 32'h0000ABCD; b = 32'h00001111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 32'h12345678; b = 32'h87654321; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 4 || {ovf, cout, sum} !== e) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d sum=%h want lat=4 sum=%h",
                     lat, sum, e[31:0]);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignore_restart: got %0d busy/done cycles want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] e;
        int cyc, cnt, last;
        @(negedge clk);
        a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
        e = model(a, b, sub, cin);
        start = 1'b1;
        cyc = 0; cnt = 0; last = -1;
        while (cnt < 5 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                checks++;
                if ({ovf, cout, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b%0d_result: got %b/%b/%h want %b/%b/%h",
                             cnt, ovf, cout, sum, e[33], e[32], e[31:0]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 5) begin
                        errors++;
                        $display("FAIL b2b%0d_period: got %0d want 5", cnt, cyc - last);
                    end
                end
                last = cyc;
                cnt++;
                a = $urandom; b = $urandom; sub = $urandom; cin = $urandom;
                e = model(a, b, sub, cin);
            end
        end
        start = 1'b0;
        checks++;
        if (cnt < 5) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d done pulses want 5", cnt);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        logic [31:0] rs;
        logic rc, ro, rb;
        int lat;
        int seen;
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 36'h0) begin
            errors++;
            $display("FAIL midop_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
                     busy, done, sum, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_nodone: got %0d busy/done cycles want 0", seen);
        end
        run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, rs, rc, ro, rb, lat);
        checks++;
        if (lat != 4 || rs !== 32'h23456789 || rc !== 1'b0 || ro !== 1'b0) begin
            errors++;
            $display("FAIL midop_rerun: got lat=%0d sum=%h cout=%b ovf=%b want lat=4 sum=23456789 cout=0 ovf=0",
                     lat, rs, rc, ro);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
